uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter that serialises bytes onto the `txd` line. It is the upstream partner of the UART receive path and drives that path's `rxd` input in loopback benches and on board.
- Generates bit timing internally from the single system clock with a cycles-per-bit counter; there is no separate divided clock.
- Accepts bytes through a valid/ready handshake.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.

Parameters:
- CLK_DIV, 434, system clock cycles per UART bit (50 MHz / 115200). Legal range ≥ 2. Counter width is clog2(CLK_DIV).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits. Legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_data  input  8  byte to transmit. Sampled only on the acceptance edge.
- tx_valid  input  1  tx_data holds a byte to send.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- txd  output  1  serial line out; idle level is high.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset: any rising edge with rst_n = 0 forces:
  - state = IDLE, txd = 1, busy = 0, tx_ready = 0, bit counter = 0, shift register = 0.
  - tx_ready goes to 1 on the first edge with rst_n = 1.
- Reset during a frame aborts it immediately. txd = 1 from that edge. No partial completion.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE → START → DATA → (PARITY, only if PARITY_EN) → STOP → IDLE.
- Acceptance: occurs on an edge where the state is IDLE and tx_valid = 1 and tx_ready = 1. On that edge:
  - tx_data is latched into the shift register and parity is computed.
  - state becomes START, txd becomes 0, tx_ready becomes 0, busy becomes 1, cycle counter becomes 0.
- tx_valid while tx_ready = 0 is ignored. Nothing is latched and the request is not queued; the upstream must hold tx_valid.
- tx_data may change freely after acceptance.
- Every bit lasts exactly CLK_DIV cycles. The counter runs 0..CLK_DIV-1; on CLK_DIV-1 it wraps to 0 and the next bit is driven.
- START: txd = 0 for one bit period.
- DATA: txd = shift[0]; shift right once per bit; an internal bit index runs 0..7. Leave DATA after bit 7.
- PARITY: txd = XOR(data) for even parity, ~XOR(data) for odd parity.
- STOP: txd = 1 for STOP_BITS bit periods. On the last cycle of the last stop bit:
  - state becomes IDLE, tx_ready becomes 1, busy becomes 0, txd stays 1.
- Frame length: FB = 10 + PARITY_EN + (STOP_BITS - 1) bits, i.e. FB·CLK_DIV cycles from the acceptance edge to IDLE.
- Back-to-back frames: tx_ready is high for at least one IDLE cycle between frames. With tx_valid held high, consecutive start-bit falling edges are exactly FB·CLK_DIV + 1 cycles apart.
- Not supported: no break generation and no FIFO. Buffering belongs in a separate block.

Test Plan (CLK_DIV = 4 unless stated):
- Reset: hold rst_n = 0 for 3 cycles with tx_valid = 1 → txd = 1, tx_ready = 0, busy = 0 throughout. tx_ready = 1 one cycle after release. No frame starts before tx_ready is seen high.
- Single byte 0x55, no parity, 1 stop: sample txd every 4 cycles from the acceptance edge → 0,1,0,1,0,1,0,1,0,1. Then txd = 1 and tx_ready = 1 exactly 40 cycles after acceptance.
- Back-to-back 0xA5 then 0x3C with tx_valid held: second start edge exactly 41 cycles after the first. Decoded bits LSB first: 1,0,1,0,0,1,0,1 and 0,0,1,1,1,1,0,0.
- Parity and stop bits:
  - PARITY_EN = 1, PARITY_ODD = 0, data 0x07 → parity bit 1, frame 11 bits (44 cycles).
  - PARITY_ODD = 1 → parity bit 0.
  - STOP_BITS = 2 → txd high for 8 cycles before IDLE.
- Reset mid-frame: assert rst_n = 0 during data bit 3 of 0x00 → txd = 1 on the next edge, busy = 0. A new byte is accepted after release and its frame is correct.
- Loopback: CLK_DIV matched to the receive path's bit timing, txd wired to its rxd, send 0x00, 0xFF, 0x5A, 0xC3 → receiver data output equals each byte in order.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: byte-wide valid/ready in, 8N1/8E1/8O1/8x2 serial frame out on txd.
// Bit timing comes from a cycles-per-bit counter on the system clock; all
// outputs come straight from flops.
module uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;     // data bit index, reused to count stop bits
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            txd_d, ready_d, busy_d;
  logic            bit_end, accept;

  assign bit_end = (cnt_q == CW'(CLK_DIV - 1));
  assign accept  = (state_q == IDLE) && tx_valid && tx_ready;

  // State and datapath registers; outputs are registered next-values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd      <= txd_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
    end
  end

  // Next-state: advance one frame field per completed bit period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && idx_q == 3'd7)
                 state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end && idx_q == 3'(STOP_BITS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next-values: txd_d is the level of the bit that starts
  // on the coming edge, so txd changes exactly on bit boundaries.
  always_comb begin
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
          idx_d   = '0;
          txd_d   = 1'b0;
        end
      end
      START: if (bit_end) begin
        txd_d = shift_q[0];
        idx_d = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (idx_q == 3'd7) begin
          idx_d = '0;
          txd_d = (PARITY_EN != 0) ? par_q : 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
          txd_d = shift_q[1];
        end
      end
      PARITY: if (bit_end) begin
        idx_d = '0;
        txd_d = 1'b1;
      end
      STOP: if (bit_end) begin
        txd_d = 1'b1;
        idx_d = (idx_q == 3'(STOP_BITS - 1)) ? 3'd0 : idx_q + 3'd1;
      end
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx instances (8N1, 8E1, 8O2) at CLK_DIV=4.
// Stimulus pushes the expected frame per accepted byte; a per-instance
// monitor decodes txd and pops/compares on every start bit it sees.
module tb_uart_tx;
  localparam int CD = 4;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;    // expected start-to-start cycles, 0 = unchecked
    logic       abort;  // frame is cut short by reset
  } exp_t;

  logic       clk;
  logic [2:0] rst_n, valid;
  logic [7:0] data [3];
  wire  [2:0] ready, txd, busy;
  int         cyc, n_cmp, n_err;
  exp_t       exp_q [3][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int PE = (g == 0) ? 0 : 1;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 2) ? 2 : 1;
    localparam int FB = 10 + PE + SB - 1;

    uart_tx #(.CLK_DIV(CD), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)) dut (
      .clk(clk), .rst_n(rst_n[g]), .tx_data(data[g]), .tx_valid(valid[g]),
      .tx_ready(ready[g]), .txd(txd[g]), .busy(busy[g]));

    // Monitor: detect start bit, sample mid-bit, check line and handshake timing.
    initial begin
      logic        prev, stop_ok, rdy_pre, bsy_pre;
      logic [11:0] got, expb;
      exp_t        e;
      int          last_start, t0, bp;
      prev = 1'b1;
      last_start = 0;
      forever begin
        @(negedge clk);
        if (rst_n[g] === 1'b1 && prev && txd[g] === 1'b0) begin
          t0 = cyc;
          if (exp_q[g].size() == 0) begin
            check($sformatf("u%0d_queue_nonempty", g), exp_q[g].size(), 1);
            e.abort = 1'b1;
            e.gap = 0;
          end else begin
            e = exp_q[g].pop_front();
          end
          if (e.gap > 0) check($sformatf("u%0d_start_gap", g), t0 - last_start, e.gap);
          last_start = t0;
          if (e.abort) begin
            for (int n = 0; n < FB * CD && busy[g]; n++) @(negedge clk);
            check($sformatf("u%0d_abort_busy", g), busy[g], 0);
          end else begin
            got = '1;
            stop_ok = 1'b1;
            rdy_pre = 1'b0;
            bsy_pre = 1'b0;
            for (int n = 1; n <= FB * CD; n++) begin
              @(negedge clk);
              bp = n / CD;
              if (n % CD == 2 && bp < FB) got[bp] = txd[g];
              if (bp >= 9 + PE && n < FB * CD && txd[g] !== 1'b1) stop_ok = 1'b0;
              if (n == FB * CD - 1) begin
                rdy_pre = ready[g];
                bsy_pre = busy[g];
              end
            end
            expb = '1;
            expb[0] = 1'b0;
            expb[8:1] = e.data;
            if (PE != 0) expb[9] = e.par;
            check($sformatf("u%0d_data", g), got[8:1], e.data);
            check($sformatf("u%0d_frame_bits", g), got, expb);
            check($sformatf("u%0d_stop_high", g), stop_ok, 1);
            check($sformatf("u%0d_ready_pre_end", g), rdy_pre, 0);
            check($sformatf("u%0d_busy_pre_end", g), bsy_pre, 1);
            check($sformatf("u%0d_ready_end", g), ready[g], 1);
            check($sformatf("u%0d_busy_end", g), busy[g], 0);
            check($sformatf("u%0d_txd_end", g), txd[g], 1);
          end
        end
        prev = txd[g];
      end
    end
  end

  // Present a byte at a negedge, wait for the handshake, record the expected frame.
  task automatic send(input int g, input logic [7:0] d, input logic p,
                      input int gap, input bit hold, input bit abort);
    exp_t e;
    int   n;
    data[g]  = d;
    valid[g] = 1'b1;
    n = 0;
    while (ready[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready[g] !== 1'b1) begin
      check($sformatf("u%0d_handshake", g), ready[g], 1);
      valid[g] = 1'b0;
      return;
    end
    e.data = d;
    e.par = p;
    e.gap = gap;
    e.abort = abort;
    exp_q[g].push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid[g] = 1'b0;
  endtask

  // Stimulus: reset, directed bytes, back-to-back, mid-frame reset, parity/stop variants.
  initial begin
    logic [7:0] lb [4];
    lb = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    cyc = 0;
    n_cmp = 0;
    n_err = 0;
    rst_n = '0;
    valid = 3'b001;
    data[0] = 8'h55;
    data[1] = 8'h00;
    data[2] = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("rst_txd", txd[0], 1);
      check("rst_ready", ready[0], 0);
      check("rst_busy", busy[0], 0);
    end
    rst_n = '1;
    @(negedge clk);
    check("rel_ready", ready[0], 1);
    check("rel_busy", busy[0], 0);
    check("rel_txd", txd[0], 1);

    send(0, 8'h55, 1'b0, 0, 1'b0, 1'b0);
    send(0, 8'hA5, 1'b0, 0, 1'b1, 1'b0);
    send(0, 8'h3C, 1'b0, 41, 1'b0, 1'b0);

    // Abort 0x00 during data bit 3 (frame cycles 16..19).
    send(0, 8'h00, 1'b0, 0, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    check("abort_txd_before", txd[0], 0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("abort_txd", txd[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_ready", ready[0], 0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", ready[0], 1);
    send(0, 8'h81, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(0, lb[i], 1'b0, 0, 1'b0, 1'b0);

    send(1, 8'h07, 1'b1, 0, 1'b0, 1'b0);
    send(2, 8'h07, 1'b0, 0, 1'b0, 1'b0);

    repeat (70) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check($sformatf("u%0d_queue_drained", g), exp_q[g].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
